// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
// Round-robin arbiter that shares the single write port of one FIFO among
// NUM_REQ producers. A producer is granted a whole burst only when the FIFO's
// free count covers the burst length. A granted burst then streams to the FIFO
// without interruption.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req_valid_in       per-requester burst request (level)
//   req_len_in         per-requester burst length, slice i = [i*LEN_WIDTH +: LEN_WIDTH]
//   data_valid_in      per-requester word valid
//   data_in            per-requester word, slice i = [i*DATA_WIDTH +: DATA_WIDTH]
//   data_ready_out     per-requester word ready (only the owner, only in BURST)
//   grant_out          one-hot current owner, zero when idle
//   fifo_free_in       FIFO free-entry count
//   fifo_data_out      FIFO write data
//   fifo_write_en_out  FIFO write enable
//   busy_out           high while a burst is in progress
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid_in,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len_in,
  input  logic [NUM_REQ-1:0]              data_valid_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   data_in,
  output logic [NUM_REQ-1:0]              data_ready_out,
  output logic [NUM_REQ-1:0]              grant_out,
  input  logic [ADDR_WIDTH:0]             fifo_free_in,
  output logic [DATA_WIDTH-1:0]           fifo_data_out,
  output logic                            fifo_write_en_out,
  output logic                            busy_out
);

  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int FREE_W = ADDR_WIDTH + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t                 state_reg;
  logic [NUM_REQ-1:0]     grant_reg;
  logic [LEN_WIDTH-1:0]   remaining_reg;
  logic [PTR_W-1:0]       ptr_reg;      // index of the last winner

  logic [LEN_WIDTH-1:0]   len_arr     [NUM_REQ];
  logic [DATA_WIDTH-1:0]  masked_data [NUM_REQ];
  logic [NUM_REQ-1:0]     cand;

  logic                   win_found;
  logic [NUM_REQ-1:0]     win_onehot;
  logic [PTR_W-1:0]       win_idx;
  logic [LEN_WIDTH-1:0]   win_len;
  logic [FREE_W-1:0]      win_len_ext;
  logic                   grant_ok;
  logic                   accept;

  // Per-requester slicing; a zero-length request is never a candidate.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign len_arr[gi]     = req_len_in[gi*LEN_WIDTH +: LEN_WIDTH];
      assign cand[gi]        = req_valid_in[gi] && (len_arr[gi] != '0);
      assign masked_data[gi] = grant_reg[gi] ? data_in[gi*DATA_WIDTH +: DATA_WIDTH]
                                             : '0;
    end
  endgenerate

  // Round-robin scan starting at ptr+1. The loop runs from the lowest priority
  // to the highest, so the last hit is the highest-priority candidate.
  always_comb begin
    int idx;
    idx        = 0;
    win_found  = 1'b0;
    win_onehot = '0;
    win_idx    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(ptr_reg) + k) % NUM_REQ;
      if (cand[idx]) begin
        win_found       = 1'b1;
        win_onehot      = '0;
        win_onehot[idx] = 1'b1;
        win_idx         = PTR_W'(idx);
      end
    end
    win_len = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_onehot[i]) win_len = len_arr[i];
    end
  end

  // The winner is never skipped: if its burst does not fit, nobody is granted.
  assign win_len_ext = FREE_W'(win_len);
  assign grant_ok    = win_found && (win_len_ext <= fifo_free_in);

  // Only the owner is ready, so an accepted word is simply owner-valid in BURST.
  assign accept = (state_reg == BURST) && (|(grant_reg & data_valid_in));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      grant_reg     <= '0;
      remaining_reg <= '0;
      ptr_reg       <= PTR_W'(NUM_REQ - 1);   // requester 0 scanned first
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_ok) begin
            state_reg     <= BURST;
            grant_reg     <= win_onehot;
            remaining_reg <= win_len;
            ptr_reg       <= win_idx;
          end
        end
        BURST: begin
          // Space was reserved at grant time; free is not re-checked here.
          if (accept) begin
            if (remaining_reg == LEN_WIDTH'(1)) begin
              state_reg     <= IDLE;
              grant_reg     <= '0;
              remaining_reg <= '0;
            end else begin
              remaining_reg <= remaining_reg - LEN_WIDTH'(1);
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    fifo_data_out = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      fifo_data_out = fifo_data_out | masked_data[i];
    end
  end

  assign grant_out         = grant_reg;
  assign busy_out          = (state_reg == BURST);
  assign data_ready_out    = rst ? '0 : grant_reg;
  assign fifo_write_en_out = accept && !rst;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed, table-driven bench for fifo_write_arbiter (4 requesters).
// Inputs are driven on the falling edge and outputs checked 1 ns later.
// Each vector holds one cycle's inputs and the outputs expected in that cycle.
module tb_fifo_write_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int LW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*LW-1:0]  req_len;
  logic [NR-1:0]     data_valid;
  logic [NR*DW-1:0]  data;
  logic [NR-1:0]     ready;
  logic [NR-1:0]     grant;
  logic [AW:0]       free;
  logic [DW-1:0]     fdata;
  logic              wen;
  logic              busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_write_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid_in(req_valid),
    .req_len_in(req_len),
    .data_valid_in(data_valid),
    .data_in(data),
    .data_ready_out(ready),
    .grant_out(grant),
    .fifo_free_in(free),
    .fifo_data_out(fdata),
    .fifo_write_en_out(wen),
    .busy_out(busy)
  );

  typedef struct {
    logic          rst;
    logic [3:0]    rv;
    logic [15:0]   len;
    logic [3:0]    dv;
    logic [4:0]    free;
    logic [3:0]    g;
    logic          wen;
    logic          busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [3:0] rv, logic [15:0] len, logic [3:0] dv,
                              logic [4:0] fr, logic [3:0] g, logic w, logic b);
    vec_t v;
    v.rst = r; v.rv = rv; v.len = len; v.dv = dv; v.free = fr;
    v.g = g; v.wen = w; v.busy = b;
    return v;
  endfunction

  // Word presented by requester i during vector k; unique per requester and cycle.
  function automatic logic [31:0] word_of(int i, int k);
    return 32'hA000_0000 + 32'(i) * 32'h0100_0000 + 32'(k);
  endfunction

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", name, k, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int owner;
    @(negedge clk);
    rst        = v.rst;
    req_valid  = v.rv;
    req_len    = v.len;
    data_valid = v.dv;
    free       = v.free;
    for (int i = 0; i < NR; i++) data[i*DW +: DW] = word_of(i, k);
    #1;
    check("grant", k, 32'(grant), 32'(v.g));
    check("ready", k, 32'(ready), v.rst ? 32'd0 : 32'(v.g));
    check("wen",   k, 32'(wen),   32'(v.wen));
    check("busy",  k, 32'(busy),  32'(v.busy));
    if (v.wen) begin
      owner = 0;
      for (int i = 0; i < NR; i++) if (v.g[i]) owner = i;
      check("data", k, fdata, word_of(owner, k));
    end
    $display("vec %0d rst=%b req=%b dv=%b free=%0d -> grant=%b ready=%b wen=%b busy=%b data=%h",
             k, v.rst, v.rv, v.dv, v.free, grant, ready, wen, busy, fdata);
  endtask

  initial begin
    // Single burst: req0 len 3
    vecs.push_back(mk(1, 4'b0000, 16'h0000, 4'b0000, 16, 4'b0000, 0, 0));  // 0 reset state
    vecs.push_back(mk(0, 4'b0001, 16'h0003, 4'b0001, 16, 4'b0000, 0, 0));  // 1
    vecs.push_back(mk(0, 4'b0001, 16'h0003, 4'b0001, 16, 4'b0001, 1, 1));  // 2
    vecs.push_back(mk(0, 4'b0001, 16'h0003, 4'b0001, 16, 4'b0001, 1, 1));  // 3
    vecs.push_back(mk(0, 4'b0001, 16'h0003, 4'b0001, 16, 4'b0001, 1, 1));  // 4
    vecs.push_back(mk(0, 4'b0000, 16'h0003, 4'b0000, 13, 4'b0000, 0, 0));  // 5
    // Round robin req0/req2 len 2 (pointer at 0, so req2 goes first)
    vecs.push_back(mk(0, 4'b0101, 16'h0202, 4'b0101, 16, 4'b0000, 0, 0));  // 6
    vecs.push_back(mk(0, 4'b0101, 16'h0202, 4'b0101, 16, 4'b0100, 1, 1));  // 7
    vecs.push_back(mk(0, 4'b0101, 16'h0202, 4'b0101, 16, 4'b0100, 1, 1));  // 8
    vecs.push_back(mk(0, 4'b0101, 16'h0202, 4'b0101, 16, 4'b0000, 0, 0));  // 9
    vecs.push_back(mk(0, 4'b0101, 16'h0202, 4'b0101, 16, 4'b0001, 1, 1));  // 10
    vecs.push_back(mk(0, 4'b0101, 16'h0202, 4'b0101, 16, 4'b0001, 1, 1));  // 11
    vecs.push_back(mk(0, 4'b0101, 16'h0202, 4'b0101, 16, 4'b0000, 0, 0));  // 12
    vecs.push_back(mk(0, 4'b0101, 16'h0202, 4'b0101, 16, 4'b0100, 1, 1));  // 13
    vecs.push_back(mk(0, 4'b0101, 16'h0202, 4'b0101, 16, 4'b0100, 1, 1));  // 14
    vecs.push_back(mk(0, 4'b0101, 16'h0202, 4'b0101, 16, 4'b0000, 0, 0));  // 15
    vecs.push_back(mk(0, 4'b0101, 16'h0202, 4'b0101, 16, 4'b0001, 1, 1));  // 16
    vecs.push_back(mk(0, 4'b0101, 16'h0202, 4'b0101, 16, 4'b0001, 1, 1));  // 17
    vecs.push_back(mk(0, 4'b0000, 16'h0202, 4'b0000, 16, 4'b0000, 0, 0));  // 18
    // Insufficient space: req1 len 5 blocks req3 len 1 until free reaches 5
    vecs.push_back(mk(0, 4'b1010, 16'h1050, 4'b1010,  2, 4'b0000, 0, 0));  // 19
    vecs.push_back(mk(0, 4'b1010, 16'h1050, 4'b1010,  2, 4'b0000, 0, 0));  // 20
    vecs.push_back(mk(0, 4'b1010, 16'h1050, 4'b1010,  5, 4'b0000, 0, 0));  // 21
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 4'b1010, 16'h1050, 4'b1010, 5, 4'b0010, 1, 1)); // 22-26
    vecs.push_back(mk(0, 4'b1000, 16'h1050, 4'b1010,  5, 4'b0000, 0, 0));  // 27
    vecs.push_back(mk(0, 4'b1000, 16'h1050, 4'b1010,  5, 4'b1000, 1, 1));  // 28
    vecs.push_back(mk(0, 4'b0000, 16'h1050, 4'b0000,  5, 4'b0000, 0, 0));  // 29
    // Gaps and isolation: req0 len 4, non-owners always valid
    vecs.push_back(mk(0, 4'b0001, 16'h0004, 4'b1110, 16, 4'b0000, 0, 0));  // 30
    vecs.push_back(mk(0, 4'b0001, 16'h0004, 4'b1111, 16, 4'b0001, 1, 1));  // 31
    vecs.push_back(mk(0, 4'b0001, 16'h0004, 4'b1110, 16, 4'b0001, 0, 1));  // 32
    vecs.push_back(mk(0, 4'b0001, 16'h0004, 4'b1110, 16, 4'b0001, 0, 1));  // 33
    vecs.push_back(mk(0, 4'b0001, 16'h0004, 4'b1111, 16, 4'b0001, 1, 1));  // 34
    vecs.push_back(mk(0, 4'b0001, 16'h0004, 4'b1111, 16, 4'b0001, 1, 1));  // 35
    vecs.push_back(mk(0, 4'b0001, 16'h0004, 4'b1111, 16, 4'b0001, 1, 1));  // 36
    vecs.push_back(mk(0, 4'b0000, 16'h0004, 4'b1110, 16, 4'b0000, 0, 0));  // 37
    // len = 0 is never granted
    vecs.push_back(mk(0, 4'b0110, 16'h0100, 4'b0110, 16, 4'b0000, 0, 0));  // 38
    vecs.push_back(mk(0, 4'b0110, 16'h0100, 4'b0110, 16, 4'b0100, 1, 1));  // 39
    vecs.push_back(mk(0, 4'b0010, 16'h0100, 4'b0010, 16, 4'b0000, 0, 0));  // 40
    vecs.push_back(mk(0, 4'b0010, 16'h0100, 4'b0010, 16, 4'b0000, 0, 0));  // 41
    // Reset mid-burst (req0 len 4), then req0/req3 contention
    vecs.push_back(mk(0, 4'b0001, 16'h0004, 4'b0001, 16, 4'b0000, 0, 0));  // 42
    vecs.push_back(mk(0, 4'b0001, 16'h0004, 4'b0001, 16, 4'b0001, 1, 1));  // 43
    vecs.push_back(mk(0, 4'b0001, 16'h0004, 4'b0001, 16, 4'b0001, 1, 1));  // 44
    vecs.push_back(mk(1, 4'b0001, 16'h0004, 4'b0001, 16, 4'b0001, 0, 1));  // 45
    vecs.push_back(mk(0, 4'b1001, 16'h2002, 4'b1001, 16, 4'b0000, 0, 0));  // 46
    vecs.push_back(mk(0, 4'b1001, 16'h2002, 4'b1001, 16, 4'b0001, 1, 1));  // 47
    vecs.push_back(mk(0, 4'b1001, 16'h2002, 4'b1001, 16, 4'b0001, 1, 1));  // 48
    vecs.push_back(mk(0, 4'b1000, 16'h2002, 4'b1000, 16, 4'b0000, 0, 0));  // 49
    vecs.push_back(mk(0, 4'b1000, 16'h2002, 4'b1000, 16, 4'b1000, 1, 1));  // 50
    vecs.push_back(mk(0, 4'b1000, 16'h2002, 4'b1000, 16, 4'b1000, 1, 1));  // 51
    vecs.push_back(mk(0, 4'b0000, 16'h2002, 4'b0000, 16, 4'b0000, 0, 0));  // 52

    rst        = 1'b1;
    req_valid  = '0;
    req_len    = '0;
    data_valid = '0;
    data       = '0;
    free       = 5'd16;
    repeat (2) @(posedge clk);

    for (int k = 0; k < vecs.size(); k++) run_vec(vecs[k], k);

    // Long owner gap: the burst simply waits, with no timeout, until the word arrives.
    run_vec(mk(0, 4'b0100, 16'h0100, 4'b0000, 16, 4'b0000, 0, 0), 100);
    for (int c = 0; c < 10; c++)
      run_vec(mk(0, 4'b0100, 16'h0100, 4'b1011, 16, 4'b0100, 0, 1), 101 + c);
    run_vec(mk(0, 4'b0100, 16'h0100, 4'b1111, 16, 4'b0100, 1, 1), 111);
    run_vec(mk(0, 4'b0000, 16'h0100, 4'b0000, 16, 4'b0000, 0, 0), 112);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
